// File: rtl/vpu_ub_writeback.sv
// vpu_ub_writeback: receiving end of the VPU output path. Each of the four
// free-running VPU lanes is tagged with its UB address and buffered in a
// small per-lane FIFO. The FIFOs are drained round-robin through one
// registered write port. A one-cycle done pulse follows the last committed
// element of a layer.
// Optional feature: define VPU_WB_CHECKSUM_EN to add wb_checksum. This is
// the XOR of all data written since the last accepted start.
// Handshake: ub_wr_en is a registered valid with ub_wr_addr/ub_wr_data as
// its payload. A word moves on a clock edge where ub_wr_en && ub_wr_ready.
// Until then the payload holds stable. The VPU lanes have no ready signal;
// an element that meets a full FIFO is dropped and flagged.
module vpu_ub_writeback #(
  parameter int LANES      = 4,
  parameter int B          = 8,
  parameter int D_OUT      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       vpu_data_in_1,
  input  logic [15:0]       vpu_data_in_2,
  input  logic [15:0]       vpu_data_in_3,
  input  logic [15:0]       vpu_data_in_4,
  input  logic              vpu_valid_in_1,
  input  logic              vpu_valid_in_2,
  input  logic              vpu_valid_in_3,
  input  logic              vpu_valid_in_4,
  output logic              ub_wr_en,
  output logic [ADDR_W-1:0] ub_wr_addr,
  output logic [15:0]       ub_wr_data,
  input  logic              ub_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow_err
`ifdef VPU_WB_CHECKSUM_EN
  ,
  output logic [15:0]       wb_checksum
`endif
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW = (B > 1) ? $clog2(B) : 1;
  localparam int CW = $clog2(D_OUT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = ADDR_W + 16;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LW-1:0]     rr;

  logic [LANES-1:0]  vld;
  logic [15:0]       din [LANES];

  logic [RW-1:0]     row_q [LANES];
  logic [CW-1:0]     col_q [LANES];
  logic [EW-1:0]     mem   [LANES][FIFO_DEPTH];
  logic [PW-1:0]     wp    [LANES];
  logic [PW-1:0]     rp    [LANES];
  logic [NW-1:0]     cnt   [LANES];
  logic [EW-1:0]     inc   [LANES];

  logic [LANES-1:0]  fin, fin_nxt, acc, req, byp, pop, push, drop, empty_nxt;
  logic [LW-1:0]     gnt, cand;
  logic              gnt_vld, slot_free, take, out_busy_nxt, start_acc, layer_end;
  logic [EW-1:0]     sel;

  assign vld    = {vpu_valid_in_4, vpu_valid_in_3, vpu_valid_in_2, vpu_valid_in_1};
  assign din[0] = vpu_data_in_1;
  assign din[1] = vpu_data_in_2;
  assign din[2] = vpu_data_in_3;
  assign din[3] = vpu_data_in_4;

  // Per-lane acceptance, address tagging and arbitration request.
  // An empty lane with a fresh element may request so it can bypass its FIFO.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      fin[k] = (col_q[k] == CW'(D_OUT));
      acc[k] = (state == S_ACTIVE) && vld[k] && !fin[k];
      inc[k] = {base_q + ADDR_W'((int'(col_q[k]) * LANES + k) * B + int'(row_q[k])), din[k]};
      req[k] = (cnt[k] != '0) || acc[k];
    end
  end

  // Round-robin: first requesting lane at or after the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int i = 0; i < LANES; i++) begin
      cand = LW'((int'(rr) + i) % LANES);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign slot_free    = !ub_wr_en || ub_wr_ready;
  assign take         = slot_free && gnt_vld;
  assign out_busy_nxt = take || (ub_wr_en && !ub_wr_ready);
  assign start_acc    = start && (state == S_IDLE);

  // FIFO push/pop/drop decisions. Fullness is judged before this cycle's pop.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      byp[k]       = take && (gnt == LW'(k)) && (cnt[k] == '0);
      pop[k]       = take && (gnt == LW'(k)) && (cnt[k] != '0);
      push[k]      = acc[k] && !byp[k] && (cnt[k] != NW'(FIFO_DEPTH));
      drop[k]      = acc[k] && !byp[k] && (cnt[k] == NW'(FIFO_DEPTH));
      fin_nxt[k]   = fin[k] || (acc[k] && (row_q[k] == RW'(B - 1)) && (col_q[k] == CW'(D_OUT - 1)));
      empty_nxt[k] = ((cnt[k] == '0) && !push[k]) ||
                     ((cnt[k] == NW'(1)) && pop[k] && !push[k]);
    end
    sel = (cnt[gnt] != '0) ? mem[gnt][rp[gnt]] : inc[gnt];
  end

  // The layer is complete once every lane has seen all its elements
  // and nothing remains in a FIFO or the output register.
  assign layer_end = ((state == S_ACTIVE) || (state == S_DRAIN)) &&
                     (&fin_nxt) && (&empty_nxt) && !out_busy_nxt;

  // Layer control FSM with registered busy/done and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      base_q       <= '0;
      overflow_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            state        <= S_ACTIVE;
            busy         <= 1'b1;
            base_q       <= base_addr;
            overflow_err <= 1'b0;
          end
        end
        S_ACTIVE, S_DRAIN: begin
          if (layer_end) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (&fin_nxt) begin
            state <= S_DRAIN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (|drop) overflow_err <= 1'b1;
    end
  end

  // Per-lane row/column counters and FIFO pointers.
  // The counters advance on every accepted element, including dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        row_q[k] <= '0;
        col_q[k] <= '0;
        wp[k]    <= '0;
        rp[k]    <= '0;
        cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (start_acc) begin
          row_q[k] <= '0;
          col_q[k] <= '0;
          wp[k]    <= '0;
          rp[k]    <= '0;
          cnt[k]   <= '0;
        end else begin
          if (acc[k]) begin
            if (row_q[k] == RW'(B - 1)) begin
              row_q[k] <= '0;
              col_q[k] <= col_q[k] + CW'(1);
            end else begin
              row_q[k] <= row_q[k] + RW'(1);
            end
          end
          if (push[k]) wp[k] <= wp[k] + PW'(1);
          if (pop[k])  rp[k] <= rp[k] + PW'(1);
          cnt[k] <= cnt[k] + NW'(push[k]) - NW'(pop[k]);
        end
      end
    end
  end

  // FIFO storage. Contents are qualified by cnt, so they need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (push[k]) mem[k][wp[k]] <= inc[k];
    end
  end

  // Output register: load the next grant whenever the slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ub_wr_en   <= 1'b0;
      ub_wr_addr <= '0;
      ub_wr_data <= '0;
      rr         <= '0;
    end else begin
      if (take) begin
        ub_wr_en                 <= 1'b1;
        {ub_wr_addr, ub_wr_data} <= sel;
        rr                       <= (gnt == LW'(LANES - 1)) ? '0 : gnt + LW'(1);
      end else if (ub_wr_ready) begin
        ub_wr_en <= 1'b0;
      end
      if (start_acc) rr <= '0;
    end
  end

`ifdef VPU_WB_CHECKSUM_EN
  logic xfer;
  assign xfer = ub_wr_en && ub_wr_ready;

  // Running XOR of committed write data for the current layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wb_checksum <= '0;
    else if (start_acc) wb_checksum <= '0;
    else if (xfer)      wb_checksum <= wb_checksum ^ ub_wr_data;
  end
`endif

endmodule

// File: tb/tb_vpu_ub_writeback.sv
// tb_vpu_ub_writeback: randomized and directed stimulus for vpu_ub_writeback.
// Expected behaviour comes from a queue-based reference model: one queue per
// lane, one output slot, and an element index per lane. Addresses are
// derived from the element index.
// Build with VPU_WB_CHECKSUM_EN to also exercise wb_checksum.
module tb_vpu_ub_writeback;
  localparam int LANES = 4, B = 8, D_OUT = 4, DEPTH = 4, ADDR_W = 10;
  localparam int PER_LANE = B * D_OUT;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       d [LANES];
  logic [3:0]        v = '0;
  logic              ub_wr_ready = 1'b1;
  logic              ub_wr_en, busy, done, overflow_err;
  logic [ADDR_W-1:0] ub_wr_addr;
  logic [15:0]       ub_wr_data;
`ifdef VPU_WB_CHECKSUM_EN
  logic [15:0]       wb_checksum;
`endif

  always #5 clk = ~clk;

  vpu_ub_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .vpu_data_in_1(d[0]), .vpu_data_in_2(d[1]), .vpu_data_in_3(d[2]), .vpu_data_in_4(d[3]),
    .vpu_valid_in_1(v[0]), .vpu_valid_in_2(v[1]), .vpu_valid_in_3(v[2]), .vpu_valid_in_4(v[3]),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
    .ub_wr_ready(ub_wr_ready), .busy(busy), .done(done), .overflow_err(overflow_err)
`ifdef VPU_WB_CHECKSUM_EN
    , .wb_checksum(wb_checksum)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  logic [25:0]       mq [LANES][$];
  logic [15:0]       exp_q [$];
  bit                m_busy, m_done, m_err, m_en;
  logic [ADDR_W-1:0] m_addr, m_base;
  logic [15:0]       m_data, m_sum;
  int                m_ptr;
  int                m_idx [LANES];
  int                m_xfers = 0;
  int                dut_wr_cnt = 0, dut_done_cnt = 0;
  bit                rr_on = 0, watch_on = 0;
  logic [ADDR_W-1:0] watch_addr = '0;
  logic [15:0]       watch_data = '0;
  int                watch_seen = 0;
  int                n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input int k, input int n);
    int r, c;
    r = n % B;
    c = n / B;
    return ADDR_W'((int'(m_base) + (c * LANES + k) * B + r) & ((1 << ADDR_W) - 1));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LANES; k++) begin
      mq[k].delete();
      m_idx[k] = 0;
    end
    m_busy = 0; m_done = 0; m_err = 0; m_en = 0;
    m_addr = '0; m_data = '0; m_base = '0; m_sum = '0; m_ptr = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int          pre [LANES];
    bit          acc [LANES];
    bit          byp [LANES];
    logic [25:0] inc [LANES];
    logic [25:0] o;
    bit          took, all_in, all_empty;
    int          g, j;
    if (m_en && ub_wr_ready) begin
      m_sum ^= m_data;
      m_xfers++;
    end
    for (int k = 0; k < LANES; k++) begin
      pre[k] = mq[k].size();
      acc[k] = m_busy && v[k] && (m_idx[k] < PER_LANE);
      byp[k] = 0;
      inc[k] = {exp_addr(k, m_idx[k]), d[k]};
    end
    took = 0; g = 0;
    if (!m_en || ub_wr_ready) begin
      for (int i = 0; i < LANES; i++) begin
        j = (m_ptr + i) % LANES;
        if (!took && (pre[j] > 0 || acc[j])) begin took = 1; g = j; end
      end
    end
    if (took) begin
      if (pre[g] > 0) o = mq[g].pop_front();
      else begin o = inc[g]; byp[g] = 1; end
      m_en = 1; m_addr = o[25:16]; m_data = o[15:0];
      m_ptr = (g + 1) % LANES;
    end else if (ub_wr_ready) begin
      m_en = 0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (acc[k]) begin
        m_idx[k]++;
        if (!byp[k]) begin
          if (pre[k] >= DEPTH) m_err = 1;
          else mq[k].push_back(inc[k]);
        end
      end
    end
    all_in = 1; all_empty = 1;
    for (int k = 0; k < LANES; k++) begin
      if (m_idx[k] != PER_LANE) all_in = 0;
      if (mq[k].size() != 0) all_empty = 0;
    end
    if (m_done) m_done = 0;
    else if (!m_busy && start) begin
      m_busy = 1; m_base = base_addr; m_err = 0; m_sum = '0; m_ptr = 0;
      for (int k = 0; k < LANES; k++) m_idx[k] = 0;
    end else if (m_busy && all_in && all_empty && !m_en) begin
      m_busy = 0; m_done = 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("wr_en", 32'(ub_wr_en), 32'(m_en));
    if (m_en) begin
      check_eq("wr_addr", 32'(ub_wr_addr), 32'(m_addr));
      check_eq("wr_data", 32'(ub_wr_data), 32'(m_data));
    end
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("overflow_err", 32'(overflow_err), 32'(m_err));
`ifdef VPU_WB_CHECKSUM_EN
    if (m_done) check_eq("checksum", 32'(wb_checksum), 32'(m_sum));
`endif
    if (ub_wr_en && ub_wr_ready) begin
      dut_wr_cnt++;
      if (watch_on && ub_wr_addr == watch_addr) begin
        watch_seen++;
        watch_data = ub_wr_data;
      end
      if (rr_on && exp_q.size() > 0) check_eq("rr_order", 32'(ub_wr_data), 32'(exp_q.pop_front()));
    end
    if (done) dut_done_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_outputs();
    if (rst_n) model_step();
    else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [ADDR_W-1:0] base);
    start = 1'b1; base_addr = base; v = '0;
    step();
    start = 1'b0;
  endtask

  task automatic finish_layer(input int pv, input int pr, input bit zero_data, input int budget);
    int cyc = 0;
    while ((m_busy || m_done) && cyc < budget) begin
      for (int k = 0; k < LANES; k++) begin
        v[k] = ($urandom_range(99) < pv);
        d[k] = zero_data ? 16'h0 : 16'($urandom);
      end
      ub_wr_ready = ($urandom_range(99) < pr);
      step();
      cyc++;
    end
    v = '0; ub_wr_ready = 1'b1;
    check_eq("layer_timeout", 32'(m_busy || m_done), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wr0, dn0, cyc, x0;
    logic [15:0] tag_data;
    int lane_cnt [LANES];
    for (int k = 0; k < LANES; k++) d[k] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_wr_en", 32'(ub_wr_en), 32'd0);
    check_eq("reset_wr_addr", 32'(ub_wr_addr), 32'd0);
    check_eq("reset_wr_data", 32'(ub_wr_data), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_err", 32'(overflow_err), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single element: visible on the write port one cycle later.
    start_layer(10'h100);
    v = 4'b0001; d[0] = 16'h0A0B;
    step();
    v = '0;
    check_eq("single_en", 32'(ub_wr_en), 32'd1);
    check_eq("single_addr", 32'(ub_wr_addr), 32'h100);
    check_eq("single_data", 32'(ub_wr_data), 32'h0A0B);
    finish_layer(60, 80, 0, 3000);

    // Full layer, one lane per cycle in rotation, ready always high.
    wr0 = dut_wr_cnt; dn0 = dut_done_cnt;
    start_layer(10'h080);
    watch_on = 1; watch_addr = 10'h080 + 10'd43; watch_seen = 0;
    tag_data = '0;
    for (int k = 0; k < LANES; k++) lane_cnt[k] = 0;
    for (int i = 0; i < LANES * PER_LANE; i++) begin
      v = '0;
      v[i % LANES] = 1'b1;
      d[i % LANES] = 16'($urandom);
      if (i % LANES == 1 && lane_cnt[1] == 11) tag_data = d[1];
      lane_cnt[i % LANES]++;
      step();
    end
    finish_layer(0, 100, 0, 50);
    watch_on = 0;
    check_eq("full_writes", 32'(dut_wr_cnt - wr0), 32'd128);
    check_eq("full_done_pulses", 32'(dut_done_cnt - dn0), 32'd1);
    check_eq("full_no_overflow", 32'(overflow_err), 32'd0);
    check_eq("lane2_r3_p1_seen", 32'(watch_seen), 32'd1);
    check_eq("lane2_r3_p1_data", 32'(watch_data), 32'(tag_data));

    // Backpressure with a single streaming lane.
    dn0 = dut_done_cnt;
    start_layer(10'h200);
    for (int i = 0; i < 8; i++) begin
      v = 4'b0001; d[0] = 16'($urandom);
      ub_wr_ready = (i >= 6);
      step();
    end
    v = '0;
    check_eq("bp_overflow", 32'(overflow_err), 32'd1);
    finish_layer(50, 70, 0, 3000);
    check_eq("bp_done", 32'(dut_done_cnt - dn0), 32'd1);

    // Round-robin order with held output while ready is low.
    start_layer(10'h040);
    rr_on = 1;
    for (int k = 0; k < LANES; k++) begin
      d[k] = 16'(k + 1);
      exp_q.push_back(16'(k + 1));
    end
    v = 4'hF; ub_wr_ready = 1'b0;
    step();
    v = '0;
    step(); step(); step();
    ub_wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("rr_all_written", 32'(exp_q.size()), 32'd0);
    rr_on = 0;
    finish_layer(40, 90, 0, 3000);

    // Random layers, including bases that wrap the address space.
    for (int n = 0; n < 4; n++) begin
      start_layer(n == 0 ? 10'h3F0 : 10'($urandom));
      finish_layer(int'($urandom_range(20, 90)), int'($urandom_range(30, 100)), 0, 4000);
    end

    // Reset in the middle of a layer.
    start_layer(10'h155);
    x0 = m_xfers; cyc = 0;
    while (m_xfers < x0 + 10 && cyc < 500) begin
      for (int k = 0; k < LANES; k++) begin
        v[k] = ($urandom_range(99) < 50);
        d[k] = 16'($urandom);
      end
      ub_wr_ready = 1'b1;
      step();
      cyc++;
    end
    v = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("midrst_wr_en", 32'(ub_wr_en), 32'd0);
    check_eq("midrst_addr", 32'(ub_wr_addr), 32'd0);
    check_eq("midrst_data", 32'(ub_wr_data), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_err", 32'(overflow_err), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    start_layer(10'h010);
    v = 4'b0001; d[0] = 16'h1234;
    step();
    v = '0;
    check_eq("post_rst_en", 32'(ub_wr_en), 32'd1);
    check_eq("post_rst_addr", 32'(ub_wr_addr), 32'h010);
    check_eq("post_rst_data", 32'(ub_wr_data), 32'h1234);
    check_eq("post_rst_err", 32'(overflow_err), 32'd0);
    finish_layer(60, 80, 0, 3000);

`ifdef VPU_WB_CHECKSUM_EN
    // Checksum: three distinct patterns, everything else zero.
    start_layer(10'h000);
    v = 4'b0111; d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h4444; d[3] = 16'h0;
    step();
    v = '0;
    finish_layer(30, 100, 1, 3000);
    check_eq("checksum_7777", 32'(wb_checksum), 32'h7777);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
